// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - DIGITS-wide 7-segment controller: static and scanned outputs, double-buffered load.
// Optional SEG7_BCD_CLAMP_EN: nibbles 10..15 decode to a dash instead of hex letters.
module seg7_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [DIGITS-1:0]     dp_static,
  output logic [6:0]            seg_scan,
  output logic                  dp_scan,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick,
  output logic                  update_pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       shown_idx;
  logic                scan_started;
  logic [BW-1:0]       bcnt;
  logic                phase;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic                term;
  logic                wrap;
  logic [IW-1:0]       sel_next;
  logic                started_next;
  logic [7*DIGITS-1:0] seg_n;
  logic [DIGITS-1:0]   dp_n;
  logic [6:0]          scan_seg;
  logic                scan_dp;
  logic [DIGITS-1:0]   scan_sel;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
`ifdef SEG7_BCD_CLAMP_EN
    if (n > 4'd9) g = 7'b0111111;
`endif
    return g;
  endfunction

  assign term = (presc == P_LAST);
  assign wrap = term && (idx == I_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      bcnt       <= '0;
      phase      <= 1'b0;
    end else begin
      presc      <= term ? '0 : presc + 1'b1;
      if (term) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      frame_tick <= wrap;
      bcnt       <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
      if (bcnt == B_LAST) phase <= ~phase;
    end
  end

  // A load landing on the wrap edge bypasses the shadow wait entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val     <= '0;
      shadow_dp      <= '0;
      disp_val       <= '0;
      disp_dp        <= '0;
      update_pending <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      if (wrap) begin
        disp_val       <= value;
        disp_dp        <= dp_in;
        update_pending <= 1'b0;
      end else begin
        update_pending <= 1'b1;
      end
    end else if (wrap) begin
      disp_val       <= shadow_val;
      disp_dp        <= shadow_dp;
      update_pending <= 1'b0;
    end
  end

  // Walk from the top digit down so nz tells whether any higher-or-equal nibble is nonzero.
  always_comb begin
    logic nz;
    nz    = 1'b0;
    seg_n = '1;
    dp_n  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (disp_val[4*i +: 4] != 4'h0);
      if (phase && blink_mask[i]) begin
        seg_n[7*i +: 7] = 7'h7F;
        dp_n[i]         = 1'b1;
      end else begin
        seg_n[7*i +: 7] = (blank_lz && (i != 0) && !nz) ? 7'h7F : decode(disp_val[4*i +: 4]);
        dp_n[i]         = ~disp_dp[i];
      end
    end
  end

  assign sel_next     = term ? idx : shown_idx;
  assign started_next = scan_started | term;

  always_comb begin
    scan_seg = 7'h7F;
    scan_dp  = 1'b1;
    scan_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_next == IW'(i)) begin
        scan_seg    = seg_n[7*i +: 7];
        scan_dp     = dp_n[i];
        scan_sel[i] = 1'b0;
      end
    end
  end

  // The scan bus latches the finished slot's digit on the same edge the index moves on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_static   <= '1;
      dp_static    <= '1;
      seg_scan     <= 7'h7F;
      dp_scan      <= 1'b1;
      dig_sel      <= '1;
      shown_idx    <= '0;
      scan_started <= 1'b0;
    end else begin
      seg_static   <= seg_n;
      dp_static    <= dp_n;
      shown_idx    <= sel_next;
      scan_started <= started_next;
      if (started_next) begin
        seg_scan <= scan_seg;
        dp_scan  <= scan_dp;
        dig_sel  <= scan_sel;
      end else begin
        seg_scan <= 7'h7F;
        dp_scan  <= 1'b1;
        dig_sel  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - cycle-level reference model bench for seg7_display_ctrl.
module tb_seg7_display_ctrl;
  localparam int D = 4, SD = 4, BD = 8;

  logic clk = 1'b0, reset_n = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, blink_mask = '0;
  logic [27:0] seg_static;
  logic [3:0]  dp_static, dig_sel;
  logic [6:0]  seg_scan;
  logic        dp_scan, frame_tick, update_pending;

  seg7_display_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .seg_static(seg_static),
    .dp_static(dp_static), .seg_scan(seg_scan), .dp_scan(dp_scan), .dig_sel(dig_sel),
    .frame_tick(frame_tick), .update_pending(update_pending));

  always #5 clk = ~clk;

  int vectors = 0, errs = 0;
  int n = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic [3:0]  m_dpd = '0, m_dps = '0;
  logic        m_pend = 1'b0;
  logic [27:0] e_seg;
  logic [3:0]  e_dp, e_sel;
  logic [6:0]  e_sscan;
  logic        e_dpscan, e_tick;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
`ifdef SEG7_BCD_CLAMP_EN
    if (v > 4'd9) g = 7'h3F;
`endif
    return g;
  endfunction

  // Returns {dp active-low, seg} for digit i of the currently displayed value.
  function automatic logic [7:0] digit_out(input int i, input int ph);
    logic [6:0] s;
    if (ph == 1 && blink_mask[i]) return 8'hFF;
    if (blank_lz && i > 0 && (m_disp >> (4 * i)) == 16'h0) s = 7'h7F;
    else s = hex_glyph(m_disp[4*i +: 4]);
    return {~m_dpd[i], s};
  endfunction

  task automatic model_edge();
    int ph, idx, sh;
    bit term, wrap;
    ph   = (n / BD) % 2;
    idx  = (n / SD) % D;
    term = (n % SD) == SD - 1;
    wrap = term && idx == D - 1;
    for (int i = 0; i < D; i++) {e_dp[i], e_seg[7*i +: 7]} = digit_out(i, ph);
    if (n + 1 < SD) begin
      e_sel = 4'hF; e_sscan = 7'h7F; e_dpscan = 1'b1;
    end else begin
      sh = ((n + 1) / SD - 1) % D;
      e_sel = ~(4'b0001 << sh);
      {e_dpscan, e_sscan} = digit_out(sh, ph);
    end
    e_tick = wrap;
    if (load) begin
      m_shadow = value; m_dps = dp_in;
      if (wrap) begin m_disp = value; m_dpd = dp_in; m_pend = 1'b0; end
      else m_pend = 1'b1;
    end else if (wrap) begin
      m_disp = m_shadow; m_dpd = m_dps; m_pend = 1'b0;
    end
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    chk("seg_static", 32'(seg_static), 32'(e_seg));
    chk("dp_static", 32'(dp_static), 32'(e_dp));
    chk("seg_scan", 32'(seg_scan), 32'(e_sscan));
    chk("dp_scan", 32'(dp_scan), 32'(e_dpscan));
    chk("dig_sel", 32'(dig_sel), 32'(e_sel));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    chk("update_pending", 32'(update_pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = frame_tick;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_seg_static"}, 32'(seg_static), 32'h0FFF_FFFF);
    chk({tag, "_dp_static"}, 32'(dp_static), 32'hF);
    chk({tag, "_seg_scan"}, 32'(seg_scan), 32'h7F);
    chk({tag, "_dig_sel"}, 32'(dig_sel), 32'hF);
    chk({tag, "_pending"}, 32'(update_pending), 32'h0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    logic [6:0] a, b;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    do_load(16'h9999, 4'hF);
    step();
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    n = 0; m_disp = '0; m_shadow = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // buffered load mid-frame
    while (n % 16 != 6) step();
    do_load(16'h12AF, 4'h0);
    chk("pending_after_load", 32'(update_pending), 32'd1);
    wait_tick("tick_12af");
    step();
    chk("d0_F_glyph", 32'(seg_static[6:0]), 32'h0E);
    chk("d3_1_glyph", 32'(seg_static[27:21]), 32'h79);

    // last load in a frame wins
    do_load(16'h1111, 4'h0);
    step();
    do_load(16'h2222, 4'h0);
    wait_tick("tick_2222");
    step();
    chk("last_load_wins", 32'(seg_static), 32'({4{7'h24}}));

    // load on wrap edge
    while (n % 16 != 15) step();
    do_load(16'h3456, 4'h1);
    chk("wrap_load_no_pending", 32'(update_pending), 32'd0);
    step();
    chk("wrap_load_shown", 32'(seg_static), 32'({7'h30, 7'h19, 7'h12, 7'h02}));

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_tick("tick_0070");
    step();
    chk("lz_0070", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h78, 7'h40}));
    do_load(16'h0000, 4'h0);
    wait_tick("tick_0000");
    step();
    chk("lz_0000", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // decimal-digit clamp / hex letter
    do_load(16'h00B5, 4'h0);
    wait_tick("tick_00b5");
    step();
`ifdef SEG7_BCD_CLAMP_EN
    chk("b5_lz", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h3F, 7'h12}));
`else
    chk("b5_lz", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h03, 7'h12}));
`endif

    // blink on digit 1
    blank_lz = 1'b0;
    blink_mask = 4'b0010;
    do_load(16'h1234, 4'b0010);
    wait_tick("tick_blink");
    step();
    a = seg_static[13:7];
    for (int k = 0; k < BD; k++) step();
    b = seg_static[13:7];
    chk("blink_toggles", 32'(a != b), 32'd1);
    for (int k = 0; k < 24; k++) step();

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(7) == 0) begin
        load = 1'b1; value = 16'($urandom); dp_in = 4'($urandom);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(31) == 0) blink_mask = 4'($urandom);
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
